// File: rtl/spi_burst_ctrl.sv
// Register-level SPI transaction sequencer. Owns the slave chip-select, issues the
// address byte followed by data or dummy bytes to a byte-level SPI master, and
// returns read bytes one at a time with their index.
module spi_burst_ctrl #(
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             req_write,
  input  logic [6:0]       req_reg,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       req_wdata,
  output logic             ack,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [LEN_W-1:0] rd_index,
  output logic             cs_n,
  output logic             spi_start,
  output logic [7:0]       spi_addr,
  input  logic             spi_busy,
  input  logic             spi_finish,
  input  logic [7:0]       spi_data
);

  localparam int unsigned      DLY_W      = 16;
  localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(CS_SETUP - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAddr,
    StWaitAddr,
    StData,
    StWaitData,
    StHold
  } state_e;

  state_e             state_q, state_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [LEN_W-1:0]   rd_index_q, rd_index_d;
  logic               cs_n_q, cs_n_d;
  logic               spi_start_q, spi_start_d;
  logic [7:0]         spi_addr_q, spi_addr_d;
  logic               write_q, write_d;
  logic [6:0]         reg_q, reg_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [LEN_W-1:0]   cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_index_d  = rd_index_q;
    cs_n_d      = cs_n_q;
    spi_start_d = 1'b0;
    spi_addr_d  = spi_addr_q;
    write_d     = write_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          write_d = req_write;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          // Writes are always one byte; a zero read length means one byte.
          len_d   = (req_write || req_len == '0) ? LEN_W'(1) : req_len;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          dly_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (dly_q == SETUP_LAST) begin
          state_d = StAddr;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      StAddr: begin
        if (!spi_busy) begin
          spi_start_d = 1'b1;
          spi_addr_d  = {~write_q, reg_q};  // MSB set selects a read
          state_d     = StWaitAddr;
        end
      end
      StWaitAddr: begin
        // Byte received during the address phase carries no data.
        if (spi_finish) state_d = StData;
      end
      StData: begin
        if (!spi_busy) begin
          spi_start_d = 1'b1;
          spi_addr_d  = write_q ? wdata_q : 8'h00;
          state_d     = StWaitData;
        end
      end
      StWaitData: begin
        if (spi_finish) begin
          if (!write_q) begin
            rd_data_d  = spi_data;
            rd_index_d = cnt_q;
            rd_valid_d = 1'b1;
          end
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            dly_d   = '0;
            state_d = StHold;
          end else begin
            state_d = StData;
          end
        end
      end
      StHold: begin
        if (dly_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_index_q  <= '0;
      cs_n_q      <= 1'b1;
      spi_start_q <= 1'b0;
      spi_addr_q  <= '0;
      write_q     <= 1'b0;
      reg_q       <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_index_q  <= rd_index_d;
      cs_n_q      <= cs_n_d;
      spi_start_q <= spi_start_d;
      spi_addr_q  <= spi_addr_d;
      write_q     <= write_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_index  = rd_index_q;
  assign cs_n      = cs_n_q;
  assign spi_start = spi_start_q;
  assign spi_addr  = spi_addr_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with a behavioural byte-level SPI master.
module tb_spi_burst_ctrl;

  localparam int unsigned LEN_W    = 4;
  localparam int unsigned CS_SETUP = 4;
  localparam int unsigned CS_HOLD  = 4;
  localparam int          BYTE_CYC = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             req_write = 1'b0;
  logic [6:0]       req_reg = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [7:0]       req_wdata = '0;
  logic             ack, busy, done, rd_valid, cs_n, spi_start;
  logic [7:0]       rd_data, spi_addr;
  logic [LEN_W-1:0] rd_index;
  logic             spi_busy, spi_finish;
  logic [7:0]       spi_data;

  logic             m_busy;
  logic             force_busy = 1'b0;
  int               m_cnt;

  logic [7:0]       slave_q[$];
  logic [7:0]       mosi_q[$];
  logic [11:0]      rd_q[$];
  bit               done_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acks   = 0;
  int n_starts = 0;
  int starts_forced = 0;
  int guard_cyc = 0;
  int ack_cyc = 0;
  int fin_cyc = 0;
  bit in_frame = 1'b0;
  bit frame_ok = 1'b1;
  bit first_start = 1'b1;
  bit start_prev = 1'b0;

  spi_burst_ctrl #(
    .LEN_W   (LEN_W),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_write (req_write),
    .req_reg   (req_reg),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_index  (rd_index),
    .cs_n      (cs_n),
    .spi_start (spi_start),
    .spi_addr  (spi_addr),
    .spi_busy  (spi_busy),
    .spi_finish(spi_finish),
    .spi_data  (spi_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Byte-level master: one byte takes BYTE_CYC cycles, then finish with slave data.
  assign spi_busy = m_busy | force_busy;
  always @(posedge clk) begin
    if (rst) begin
      m_busy     <= 1'b0;
      spi_finish <= 1'b0;
      m_cnt      <= 0;
      spi_data   <= '0;
    end else begin
      spi_finish <= 1'b0;
      if (!m_busy && spi_start) begin
        m_busy <= 1'b1;
        m_cnt  <= BYTE_CYC;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy     <= 1'b0;
          spi_finish <= 1'b1;
          spi_data   <= (slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst) begin
      in_frame    = 1'b0;
      first_start = 1'b1;
      start_prev  = 1'b0;
    end else begin
      if (spi_finish) fin_cyc = cyc;
      if (ack) begin
        n_acks++;
        ack_cyc     = cyc;
        in_frame    = 1'b1;
        frame_ok    = 1'b1;
        first_start = 1'b1;
        check("ack_busy", 32'(busy), 32'd1);
        check("ack_cs_n", 32'(cs_n), 32'd0);
      end else if (in_frame && !done && cs_n) begin
        frame_ok = 1'b0;
      end
      if (spi_start) begin
        n_starts++;
        if (force_busy) starts_forced++;
        check("start_not_back_to_back", 32'(start_prev), 32'd0);
        if (first_start) begin
          check("first_start_cycle", cyc,
                (guard_cyc != 0) ? guard_cyc : ack_cyc + int'(CS_SETUP) + 1);
          first_start = 1'b0;
        end else begin
          check("start_after_finish", cyc - fin_cyc, 32'd2);
        end
        if (mosi_q.size() > 0) check("mosi_byte", 32'(spi_addr), 32'(mosi_q.pop_front()));
        else check("unexpected_start", 32'd1, 32'd0);
      end
      start_prev = spi_start;
      if (rd_valid) begin
        if (rd_q.size() > 0) check("rd_index_data", {20'd0, rd_index, rd_data},
                                   {20'd0, rd_q.pop_front()});
        else check("unexpected_rd_valid", 32'd1, 32'd0);
        check("rd_valid_latency", cyc - fin_cyc, 32'd1);
      end
      if (done) begin
        if (done_q.size() > 0) void'(done_q.pop_front());
        else check("unexpected_done", 32'd1, 32'd0);
        check("done_latency", cyc - fin_cyc, int'(CS_HOLD) + 1);
        check("done_cs_n", 32'(cs_n), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("cs_n_low_in_frame", 32'(frame_ok), 32'd1);
        in_frame = 1'b0;
      end
    end
  end

  task automatic push_exp(input bit w, input logic [6:0] r, input logic [3:0] len,
                          input logic [7:0] wd, input logic [7:0] base);
    int n;
    n = (w || len == 0) ? 1 : int'(len);
    slave_q.push_back(8'h5A);
    mosi_q.push_back({~w, r});
    for (int i = 0; i < n; i++) begin
      mosi_q.push_back(w ? wd : 8'h00);
      slave_q.push_back(w ? 8'hEE : 8'(base + 8'(i)));
      if (!w) rd_q.push_back({4'(i), 8'(base + 8'(i))});
    end
    done_q.push_back(1'b1);
  endtask

  // Raise req and wait for ack; req inputs are then scrambled to prove latching.
  task automatic issue(input bit w, input logic [6:0] r, input logic [3:0] len,
                       input logic [7:0] wd, input bit keep_req, output int acked_at);
    bit got;
    got = 1'b0;
    acked_at = 0;
    req_write = w;
    req_reg   = r;
    req_len   = len;
    req_wdata = wd;
    req       = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got      = 1'b1;
        acked_at = cyc;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    if (!keep_req) req = 1'b0;
    req_write = ~w;
    req_reg   = 7'h7F;
    req_len   = 4'hF;
    req_wdata = 8'hC3;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a;
    int acks0;
    int starts0;
    bit reached;

    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_index", 32'(rd_index), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_addr", 32'(spi_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Six-byte read burst.
    acks0 = n_acks;
    push_exp(1'b0, 7'h3B, 4'd6, 8'h00, 8'hA0);
    issue(1'b0, 7'h3B, 4'd6, 8'h00, 1'b0, a);
    wait_done();
    check("read_ack_count", n_acks - acks0, 32'd1);

    // Single-byte write; length field ignored.
    push_exp(1'b1, 7'h6B, 4'd5, 8'h80, 8'h00);
    issue(1'b1, 7'h6B, 4'd5, 8'h80, 1'b0, a);
    wait_done();

    // Zero length read behaves as one byte.
    push_exp(1'b0, 7'h75, 4'd0, 8'h00, 8'h71);
    issue(1'b0, 7'h75, 4'd0, 8'h00, 1'b0, a);
    wait_done();

    // req held and toggled during busy; second transaction starts right after done.
    acks0 = n_acks;
    push_exp(1'b0, 7'h01, 4'd2, 8'h00, 8'h10);
    push_exp(1'b1, 7'h02, 4'd0, 8'h55, 8'h00);
    issue(1'b0, 7'h01, 4'd2, 8'h00, 1'b1, a);
    req_write = 1'b1;
    req_reg   = 7'h02;
    req_len   = 4'd0;
    req_wdata = 8'h55;
    repeat (5) @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    req = 1'b1;
    wait_done();
    @(negedge clk);
    check("b2b_ack_after_done", 32'(ack), 32'd1);
    req = 1'b0;
    wait_done();
    check("b2b_ack_count", n_acks - acks0, 32'd2);

    // Master busy forced for 10 cycles of ADDR.
    push_exp(1'b0, 7'h20, 4'd1, 8'h00, 8'h33);
    issue(1'b0, 7'h20, 4'd1, 8'h00, 1'b0, a);
    force_busy = 1'b1;
    guard_cyc  = a + int'(CS_SETUP) + 11;
    repeat (14) @(negedge clk);
    force_busy = 1'b0;
    wait_done();
    guard_cyc = 0;
    check("no_start_while_busy", starts_forced, 32'd0);

    // Reset in the middle of the third data byte of a six-byte read.
    slave_q.push_back(8'h5A);
    slave_q.push_back(8'hC0);
    slave_q.push_back(8'hC1);
    slave_q.push_back(8'hC2);
    mosi_q.push_back(8'h90);
    for (int i = 0; i < 3; i++) mosi_q.push_back(8'h00);
    rd_q.push_back({4'd0, 8'hC0});
    rd_q.push_back({4'd1, 8'hC1});
    starts0 = n_starts;
    issue(1'b0, 7'h10, 4'd6, 8'h00, 1'b0, a);
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (n_starts - starts0 >= 4) reached = 1'b1;
    end
    if (!reached) check("third_byte_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_spi_start", 32'(spi_start), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    slave_q.delete();
    check("midrst_mosi_left", mosi_q.size(), 32'd0);
    check("midrst_rd_left", rd_q.size(), 32'd0);
    repeat (5) @(negedge clk);

    // Normal one-byte read after the reset.
    push_exp(1'b0, 7'h05, 4'd1, 8'h00, 8'h99);
    issue(1'b0, 7'h05, 4'd1, 8'h00, 1'b0, a);
    wait_done();
    repeat (5) @(negedge clk);

    check("final_mosi_left", mosi_q.size(), 32'd0);
    check("final_rd_left", rd_q.size(), 32'd0);
    check("final_done_left", done_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
